// File: rtl/rx_frame_assembler.sv
// Receive framing stage behind the Manchester decoder.
// It searches for the Ethernet SFD, packs the following bits LSB-first into
// bytes, and reports frame start, frame end, byte count and framing errors.
module rx_frame_assembler #(
  parameter int MAX_BYTES = 1518,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_orig,
  input  logic             shift_enable,
  input  logic             idle,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             sof,
  output logic             eof,
  output logic             frame_err,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy
);

  localparam logic [7:0]       SFD     = 8'hD5;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [7:0] sr_shift;

  // New bits enter at the MSB so the first bit of a byte ends up in bit 0.
  assign sr_shift = {e_orig, sr[7:1]};

  // Frame state machine; every output is registered and pulses last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sr         <= 8'd0;
      bit_cnt    <= 3'd0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      frame_err  <= 1'b0;
      byte_count <= '0;
      busy       <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          // The first bit of a burst starts a fresh search window.
          if (shift_enable && !idle) begin
            sr    <= {e_orig, 7'd0};
            state <= ST_HUNT;
            busy  <= 1'b1;
          end
        end

        ST_HUNT: begin
          // Carrier lost before any SFD: silently return, nothing to report.
          if (idle) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (shift_enable) begin
            sr <= sr_shift;
            if (sr_shift == SFD) begin
              sof        <= 1'b1;
              byte_count <= '0;
              bit_cnt    <= 3'd0;
              state      <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          // Idle wins over a coincident bit; leftover bits mark a bad frame.
          if (idle) begin
            eof       <= 1'b1;
            frame_err <= (bit_cnt != 3'd0);
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end else if (shift_enable) begin
            sr      <= sr_shift;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_count < MAX_CNT) begin
                rx_data    <= sr_shift;
                rx_valid   <= 1'b1;
                byte_count <= byte_count + CNT_W'(1);
              end else begin
                state <= ST_DRAIN;
              end
            end
          end
        end

        ST_DRAIN: begin
          // Oversized frame: discard the rest and flag it when the line goes idle.
          if (idle) begin
            eof       <= 1'b1;
            frame_err <= 1'b1;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rx_frame_assembler.md
Name: rx_frame_assembler

Overview:
Receive-side stage directly downstream of the Manchester decoder in the packet processor.
- Consumes the decoded bit stream (e_orig), the per-bit shift strobe and the line-idle flag.
- Hunts for the Ethernet SFD, assembles LSB-first bytes and emits them with a valid pulse.
- Reports start/end of frame, byte count and framing errors to the packet control logic.

Parameters:
MAX_BYTES, 1518, maximum bytes accepted per frame after the SFD; further bytes are dropped and flagged.
CNT_W, 11, width of byte_count; must satisfy 2^CNT_W > MAX_BYTES.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
e_orig  in  1  decoded bit from the Manchester decoder.
shift_enable  in  1  one-cycle strobe: e_orig holds a new valid bit this cycle.
idle  in  1  line idle / end of carrier from the decoder (level).
rx_data  out  8  last assembled byte; held until the next byte.
rx_valid  out  1  one-cycle pulse: rx_data updated.
sof  out  1  one-cycle pulse: SFD detected, frame data follows.
eof  out  1  one-cycle pulse: frame that had an SFD has ended.
frame_err  out  1  one-cycle pulse coincident with eof when the frame was bad.
byte_count  out  CNT_W  bytes delivered in the current or last frame.
busy  out  1  high in HUNT, DATA and DRAIN.

Behaviour:
Clock and reset:
- One clock (clk); reset is synchronous and active-high (rst).
- rst=1: state←IDLE. rx_data, rx_valid, sof, eof, frame_err, byte_count, busy all 0. Shift register and bit counter 0.
- rst mid-frame: the frame is discarded with no eof. rst overrides every other input.

Bit handling:
- On each shift_enable: sr ← {e_orig, sr[7:1]}, so the first received bit lands in the LSB after 8 shifts.
- All outputs are registered. Pulses assert in the cycle after the triggering shift_enable or idle cycle.
- Priority rule: if idle=1, the idle action is taken and any simultaneous shift_enable bit is discarded.

States:
- IDLE:
  - On shift_enable && !idle: clear sr, shift the bit in, go to HUNT.
- HUNT (preamble / SFD search):
  - Shift every strobe.
  - If the post-shift sr == 8'hD5: pulse sof, clear byte_count and bit_cnt, go to DATA.
  - On idle: go to IDLE with no sof/eof.
- DATA:
  - Shift every strobe; bit_cnt increments 0..7 and wraps.
  - When bit_cnt wraps (8th bit) and byte_count < MAX_BYTES: rx_data ← post-shift sr, pulse rx_valid, byte_count+1.
  - When bit_cnt wraps and byte_count == MAX_BYTES: byte dropped, no rx_valid, go to DRAIN.
  - On idle with bit_cnt==0: pulse eof, frame_err=0, go to IDLE.
  - On idle with bit_cnt!=0 (dribble bits): pulse eof and frame_err, partial byte discarded, go to IDLE.
- DRAIN:
  - Ignore bits.
  - On idle: pulse eof and frame_err, go to IDLE.

Counters:
- byte_count saturates at MAX_BYTES.
- byte_count is held after eof until the next sof.

Test Plan:
1. 7×0x55 then 0xD5 then 0x12, 0x34, then idle → sof one cycle after the 64th bit. rx_valid twice with rx_data 0x12 then 0x34. eof=1, frame_err=0, byte_count=2, busy=0 after.
2. SFD, 0xAB, 3 extra bits, then idle → one rx_valid (0xAB). eof with frame_err=1. byte_count=1.
3. 16 preamble bits (0x55 0x55), no SFD, then idle → no sof/eof/rx_valid. busy returns 0.
4. MAX_BYTES=4: SFD + 6 bytes 0x01..0x06, then idle → exactly 4 rx_valid (0x01..0x04). eof+frame_err after idle. byte_count=4.
5. rst=1 for one cycle after 3 data bits of byte 2 → next cycle all outputs 0, no eof. A following clean frame (SFD + 0x5A) gives sof, rx_valid 0x5A, eof with frame_err=0.
6. In DATA, idle and shift_enable both high on the 8th bit of a byte → bit discarded, no rx_valid. eof+frame_err=1.
